// File: rtl/mips_execute_stage.sv
// MIPS execute stage: ALU, HI/LO ownership and an iterative multiply/divide unit.
// Optional FAST_MULT_EN: single-cycle combinational multiply; divide stays iterative.
module mips_execute_stage #(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter int          DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_valid_ready_go,
  input  logic [31:0] de_out_op,
  input  logic [4:0]  de_rf_waddr,
  input  logic [31:0] de_alu_in_1,
  input  logic [31:0] de_alu_in_2,
  input  logic [31:0] de_to_mem_value,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_instruction,
  input  logic        mem_allowin,
  output logic        ex_allowin,
  output logic        ex_valid,
  output logic        ex_valid_ready_go,
  output logic [31:0] ex_out_op,
  output logic [4:0]  ex_rf_waddr,
  output logic [31:0] ex_alu_result,
  output logic [31:0] ex_to_mem_value,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instruction,
  output logic [31:0] ex_hi_value,
  output logic [31:0] ex_lo_value,
  output logic        ex_busy
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  md_state_t   state, state_nxt;
  logic [31:0] ex_alu_in_1, ex_alu_in_2;
  logic [31:0] hi_q, lo_q;
  logic [31:0] acc_hi, acc_lo, md_b;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, md_is_div;

  logic        op_mult, op_div, op_hiw, op_low, md_unsigned, iter_op;
  logic        ex_ready_go, handoff, start, last_iter;
  logic [11:0] aluop;
  logic [4:0]  shamt;

  assign aluop       = ex_out_op[11:0];
  assign op_div      = ex_out_op[16];
  assign op_mult     = ex_out_op[17];
  assign op_low      = ex_out_op[18];
  assign op_hiw      = ex_out_op[19];
  assign md_unsigned = ex_instruction[0];
  assign shamt       = ex_alu_in_1[4:0];

`ifdef FAST_MULT_EN
  assign iter_op = op_div;
`else
  assign iter_op = op_div | op_mult;
`endif

  assign ex_ready_go       = !iter_op || (state == DONE);
  assign ex_valid_ready_go = ex_valid && ex_ready_go;
  assign ex_allowin        = !ex_valid || (ex_ready_go && mem_allowin);
  assign handoff           = ex_valid_ready_go && mem_allowin;
  assign start             = (state == IDLE) && ex_valid && iter_op;
  assign last_iter         = (state == RUN) && (cnt == LAST_ITER);
  assign ex_busy           = (state != IDLE);
  assign ex_hi_value       = hi_q;
  assign ex_lo_value       = lo_q;

  // One-hot ALU; an all-zero aluop yields zero.
  always_comb begin
    ex_alu_result = '0;
    if (aluop[0])  ex_alu_result = {ex_alu_in_2[15:0], 16'h0000};
    if (aluop[1])  ex_alu_result = $signed(ex_alu_in_2) >>> shamt;
    if (aluop[2])  ex_alu_result = ex_alu_in_2 >> shamt;
    if (aluop[3])  ex_alu_result = ex_alu_in_2 << shamt;
    if (aluop[4])  ex_alu_result = ex_alu_in_1 ^ ex_alu_in_2;
    if (aluop[5])  ex_alu_result = ex_alu_in_1 | ex_alu_in_2;
    if (aluop[6])  ex_alu_result = ~(ex_alu_in_1 | ex_alu_in_2);
    if (aluop[7])  ex_alu_result = ex_alu_in_1 & ex_alu_in_2;
    if (aluop[8])  ex_alu_result = {31'b0, ex_alu_in_1 < ex_alu_in_2};
    if (aluop[9])  ex_alu_result = {31'b0, $signed(ex_alu_in_1) < $signed(ex_alu_in_2)};
    if (aluop[10]) ex_alu_result = ex_alu_in_1 - ex_alu_in_2;
    if (aluop[11]) ex_alu_result = ex_alu_in_1 + ex_alu_in_2;
  end

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = !md_unsigned && ex_alu_in_1[31];
  assign b_neg = !md_unsigned && ex_alu_in_2[31];
  assign a_mag = a_neg ? -ex_alu_in_1 : ex_alu_in_1;
  assign b_mag = b_neg ? -ex_alu_in_2 : ex_alu_in_2;

  // acc_hi holds remainder / product high half, acc_lo holds shifting dividend / multiplier.
  logic [32:0] trial, msum;
  logic        ge;
  logic [31:0] iter_hi, iter_lo, fin_hi, fin_lo;
  logic [63:0] prod_mag, prod_fix;

  always_comb begin
    trial = {acc_hi, acc_lo[31]};
    ge    = trial >= {1'b0, md_b};
    msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : 33'd0);
    if (md_is_div) begin
      iter_hi = ge ? (trial[31:0] - md_b) : trial[31:0];
      iter_lo = {acc_lo[30:0], ge};
    end else begin
      iter_hi = msum[32:1];
      iter_lo = {msum[0], acc_lo[31:1]};
    end
    prod_mag = {iter_hi, iter_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    if (md_is_div) begin
      fin_lo = neg_q ? -iter_lo : iter_lo;
      fin_hi = neg_r ? -iter_hi : iter_hi;
    end else begin
      fin_hi = prod_fix[63:32];
      fin_lo = prod_fix[31:0];
    end
  end

`ifdef FAST_MULT_EN
  logic [63:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {md_unsigned ? 32'b0 : {32{ex_alu_in_1[31]}}, ex_alu_in_1};
  assign fast_b    = {md_unsigned ? 32'b0 : {32{ex_alu_in_2[31]}}, ex_alu_in_2};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
      DONE:    if (mem_allowin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid        <= 1'b0;
      ex_out_op       <= '0;
      ex_rf_waddr     <= '0;
      ex_alu_in_1     <= '0;
      ex_alu_in_2     <= '0;
      ex_to_mem_value <= '0;
      ex_pc           <= RESET_PC;
      ex_instruction  <= '0;
    end else begin
      if (ex_allowin) ex_valid <= de_valid_ready_go;
      if (de_valid_ready_go && ex_allowin) begin
        ex_out_op       <= de_out_op;
        ex_rf_waddr     <= de_rf_waddr;
        ex_alu_in_1     <= de_alu_in_1;
        ex_alu_in_2     <= de_alu_in_2;
        ex_to_mem_value <= de_to_mem_value;
        ex_pc           <= de_pc;
        ex_instruction  <= de_instruction;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      md_b      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      md_is_div <= 1'b0;
    end else if (start) begin
      acc_hi    <= '0;
      acc_lo    <= a_mag;
      md_b      <= b_mag;
      cnt       <= '0;
      neg_q     <= a_neg ^ b_neg;
      neg_r     <= a_neg;
      md_is_div <= op_div;
    end else if (state == RUN) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
      cnt    <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last_iter) begin
      hi_q <= fin_hi;
      lo_q <= fin_lo;
    end else if (handoff) begin
`ifdef FAST_MULT_EN
      if (op_mult) begin
        hi_q <= fast_prod[63:32];
        lo_q <= fast_prod[31:0];
      end
`endif
      if (!op_mult && !op_div) begin
        if (op_hiw) hi_q <= ex_alu_result;
        if (op_low) lo_q <= ex_alu_result;
      end
    end
  end

endmodule

// File: doc/mips_execute_stage.md
Name: mips_execute_stage

Overview:
Execute stage of the five-stage MIPS pipeline, directly downstream of decode. It captures the decoded op bundle, ALU operands, destination register and store data through the valid/allowin handshake. It computes the one-hot ALU result and owns the HI/LO registers. Multiply and divide run in an iterative unit that stalls the stage until the result is ready.

Parameters:
RESET_PC, 32'hbfc00000, reset value of ex_pc.
DIV_CYCLES, 32, quotient bits per divide; fixed at 32, not for override.

Ports:
clk  input  1  clock
rst  input  1  reset
de_valid_ready_go  input  1  decode holds a valid, ready instruction
de_out_op  input  32  {store[4:0],load[6:0],HIWrite,LOWrite,Mult,Div,RegWrite,MemEnable,MemWrite,WBMux,aluop[11:0]}
de_rf_waddr  input  5  destination register
de_alu_in_1  input  32  operand 1
de_alu_in_2  input  32  operand 2
de_to_mem_value  input  32  store data
de_pc  input  32  instruction PC
de_instruction  input  32  instruction word; funct[0]=1 selects unsigned mult/div
mem_allowin  input  1  memory stage can accept
ex_allowin  output  1  stage can accept
ex_valid  output  1  stage holds a valid instruction
ex_valid_ready_go  output  1  ex_valid && ex_ready_go
ex_out_op  output  32  registered op bundle
ex_rf_waddr  output  5  registered destination register
ex_alu_result  output  32  ALU result, combinational from stage registers
ex_to_mem_value  output  32  registered store data
ex_pc  output  32  registered PC
ex_instruction  output  32  registered instruction word
ex_hi_value  output  32  current HI
ex_lo_value  output  32  current LO
ex_busy  output  1  multiply/divide FSM not in IDLE

Behaviour:
- Reset: clk, rst (reset rst, synchronous, active-high; clock clk).
  - On rst: ex_valid=0, ex_pc=RESET_PC; all other stage registers, HI and LO = 0; FSM = IDLE. This also applies mid-operation and abandons any iteration in progress.
- Handshake:
  - ex_allowin = !ex_valid || (ex_ready_go && mem_allowin).
  - When ex_allowin: ex_valid <= de_valid_ready_go.
  - When de_valid_ready_go && ex_allowin: all stage registers load from the de_* inputs.
- ALU, one-hot aluop, all bits zero -> result 0:
  - Shifts use amount in_1[4:0] applied to in_2.
  - aluop[0] lui: in_2<<16.
  - aluop[1] sra (arithmetic), aluop[2] srl, aluop[3] sll.
  - aluop[4] xor, aluop[5] or, aluop[6] nor, aluop[7] and.
  - aluop[8] sltu (unsigned compare), aluop[9] slt (signed compare), result zero-extended 0/1.
  - aluop[10] in_1-in_2, aluop[11] in_1+in_2; 32-bit wrap, no overflow trap.
- ex_ready_go:
  - Equals 1 unless the op has Mult or Div set.
  - For Mult or Div, equals 1 only in state DONE.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN when ex_valid && (Mult||Div) and the op has not yet completed. This is the entry cycle T. Operands are latched as magnitudes when signed, and the counter is cleared.
  - RUN: one iteration per cycle (divide: restoring, one quotient bit; multiply: shift-add, one bit). After the 32nd iteration (cycle T+32) -> DONE, and HI/LO are written at that edge.
  - DONE: ex_ready_go=1. DONE -> IDLE when mem_allowin. A new op that enters in the same cycle is seen in IDLE on the next cycle.
  - Total EX occupancy for mult/div: 34 cycles, assuming mem_allowin is held high.
- Signed result fix-up:
  - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Product is negated when operand signs differ.
- Result placement:
  - Divide: LO=quotient, HI=remainder.
  - Multiply: {HI,LO}=64-bit product.
- Divide by zero: no trap. divu x/0 gives LO=32'hffffffff, HI=x; signed div by zero only has to complete on time.
- mthi/mtlo (HIWrite or LOWrite without Mult/Div): HI or LO <= ex_alu_result at the edge where ex_valid_ready_go && mem_allowin.
- If an mfhi in decode and a HI write in EX happen in the same cycle, decode sees the old value. Hazard detection owns forwarding.

Optional Feature:
FAST_MULT_EN.
- Defined: multiply is a single-cycle combinational 32x32. Mult ops never leave IDLE, ex_ready_go=1 immediately, and HI/LO are written at the handoff edge (ex_valid_ready_go && mem_allowin). Divide is unchanged.
- Undefined: multiply uses the iterative 34-cycle path described above.

Test Plan:
- addu, in_1=32'h7fffffff, in_2=1, aluop[11] -> ex_alu_result=32'h80000000, ex_ready_go=1 in the entry cycle.
- sra, in_1=4, in_2=32'h80000000 -> 32'hf8000000; slt with -1 vs 1 -> 1; sltu with the same operands -> 0.
- div -7/2 -> ex_allowin low for 33 cycles, LO=32'hfffffffd, HI=32'hffffffff, ex_valid_ready_go first high in cycle T+33.
- divu 5/0 -> LO=32'hffffffff, HI=5; multu 32'hffffffff*2 -> HI=1, LO=32'hfffffffe (1 cycle with FAST_MULT_EN, 34 without).
- mem_allowin low during DONE for 5 cycles -> state stays DONE, HI/LO not recomputed, exactly one handoff, then IDLE.
- rst asserted at RUN iteration 10 -> next cycle ex_valid=0, FSM=IDLE, HI=LO=0, ex_pc=32'hbfc00000.
